// File: rtl/if_prefetch.sv
// Instruction fetch front end: owns the PC, issues credit-limited word reads,
// buffers returned words and presents one registered instruction per cycle.
module if_prefetch #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter logic [31:0] NOP_INST   = 32'h00000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [29:0]   pc_word;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;

    // Addresses of reads in flight, popped in order as beats return (dropped or not).
    logic [31:0]   aq_addr [DEPTH];
    logic [AW-1:0] aq_wr;
    logic [AW-1:0] aq_rd;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW:0]   credit_used;

    logic grant;
    logic beat;
    logic keep;
    logic pop;
    logic unused_jump_lsb;

    assign unused_jump_lsb = ^jump_addr_i[1:0];

    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign ibus_req_o  = !rst && !jump_flag_i && (credit_used < DEPTH_C);
    assign ibus_addr_o = {pc_word, 2'b00};

    assign grant = ibus_req_o && ibus_gnt_i;
    // A beat with nothing outstanding is stale (e.g. issued before a reset) and is ignored.
    assign beat  = ibus_rvalid_i && (outstanding != '0);
    assign keep  = beat && (discard == '0) && !jump_flag_i;
    assign pop   = !jump_flag_i && !hold_flag_i && (fifo_count != '0);

    always_comb begin
        outstanding_next = outstanding;
        if (grant && !beat) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!grant && beat) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    always_comb begin
        fifo_count_next = fifo_count;
        case ({keep, pop})
            2'b10:   fifo_count_next = fifo_count + CW'(1);
            2'b01:   fifo_count_next = fifo_count - CW'(1);
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_word      <= RESET_ADDR[31:2];
            fifo_wr      <= '0;
            fifo_rd      <= '0;
            fifo_count   <= '0;
            aq_wr        <= '0;
            aq_rd        <= '0;
            outstanding  <= '0;
            discard      <= '0;
            inst_o       <= NOP_INST;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            outstanding <= outstanding_next;

            if (grant) begin
                aq_addr[aq_wr] <= ibus_addr_o;
                aq_wr          <= aq_wr + AW'(1);
                pc_word        <= pc_word + 30'd1;
            end
            if (beat) begin
                aq_rd <= aq_rd + AW'(1);
            end
            if (keep) begin
                fifo_data[fifo_wr] <= ibus_rdata_i;
                fifo_addr[fifo_wr] <= aq_addr[aq_rd];
            end

            if (jump_flag_i) begin
                // Every read still in flight after this edge belongs to the old stream.
                pc_word      <= jump_addr_i[31:2];
                fifo_wr      <= '0;
                fifo_rd      <= '0;
                fifo_count   <= '0;
                discard      <= outstanding_next;
                inst_o       <= NOP_INST;
                inst_valid_o <= 1'b0;
            end else begin
                if (keep) begin
                    fifo_wr <= fifo_wr + AW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + AW'(1);
                end
                fifo_count <= fifo_count_next;
                if (beat && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (!hold_flag_i) begin
                    if (pop) begin
                        inst_o       <= fifo_data[fifo_rd];
                        inst_addr_o  <= fifo_addr[fifo_rd];
                        inst_valid_o <= 1'b1;
                    end else begin
                        inst_o       <= NOP_INST;
                        inst_valid_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
